// File: rtl/mcu_cap_pkg.sv
// Shared encodings and sizes for the MCU test-bus capture block.
package mcu_cap_pkg;

    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;
    localparam int DATA_W = 32;
    localparam int LVL_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

    function automatic logic trig_hit(input logic [DATA_W-1:0] data,
                                      input logic [DATA_W-1:0] mask,
                                      input logic [DATA_W-1:0] value);
        return ((data & mask) == (value & mask));
    endfunction

endpackage

// File: rtl/mcu_cap_ram.sv
// 16x32 capture buffer: synchronous write, registered read with hold on idle.
module mcu_cap_ram
    import mcu_cap_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; array contents are left as-is.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mcu_test_capture.sv
// Trigger-based capture of the MCU test bus into a circular buffer with FIFO-style readout.
//   state | meaning
//   IDLE  | waiting for cap_start
//   ARMED | recording every cycle, looking for the trigger
//   TRIG  | recording post_len samples after the trigger
//   DONE  | capture frozen, samples readable oldest first
module mcu_test_capture
    import mcu_cap_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] test_in,
    input  logic              cap_start,
    input  logic              cap_abort,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [PTR_W-1:0]  post_len,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LVL_W-1:0]  rd_level,
    output logic [PTR_W-1:0]  trig_pos,
    output logic [1:0]        cap_state,
    output logic              cap_done
);

    cap_state_e       state_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] fill_cnt_q;
    logic [PTR_W-1:0] post_cnt_q;
    logic [PTR_W-1:0] post_len_q;
    logic [LVL_W-1:0] rd_level_q;
    logic [PTR_W-1:0] trig_pos_q;
    logic             rd_valid_q;

    logic [PTR_W-1:0] wr_ptr_d;
    logic [LVL_W-1:0] fill_cnt_d;
    logic             wr_en;
    logic             rd_fire;
    logic             hit;

    assign wr_ptr_d   = wr_ptr_q + 4'd1;
    assign fill_cnt_d = (fill_cnt_q == LVL_W'(DEPTH)) ? fill_cnt_q : fill_cnt_q + 5'd1;
    assign hit        = trig_hit(test_in, trig_mask, trig_value);

    assign wr_en   = !sys_rst && !cap_abort &&
                     ((state_q == ST_ARMED) || (state_q == ST_TRIG));
    assign rd_fire = !sys_rst && !cap_abort && !cap_start &&
                     (state_q == ST_DONE) && (rd_req == 1'b1) && (rd_level_q != '0);

    always_ff @(posedge sys_clk) begin
        rd_valid_q <= 1'b0;
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_cnt_q <= '0;
            post_cnt_q <= '0;
            post_len_q <= '0;
            rd_level_q <= '0;
            trig_pos_q <= '0;
        end else if (cap_abort) begin
            state_q    <= ST_IDLE;
            rd_level_q <= '0;
            trig_pos_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cap_start) begin
                        wr_ptr_q   <= '0;
                        fill_cnt_q <= '0;
                        rd_level_q <= '0;
                        trig_pos_q <= '0;
                        state_q    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    wr_ptr_q   <= wr_ptr_d;
                    fill_cnt_q <= fill_cnt_d;
                    if (hit) begin
                        post_len_q <= post_len;
                        if (post_len == '0) begin
                            rd_ptr_q   <= wr_ptr_d - fill_cnt_d[PTR_W-1:0];
                            rd_level_q <= fill_cnt_d;
                            trig_pos_q <= fill_cnt_d[PTR_W-1:0] - 4'd1;
                            state_q    <= ST_DONE;
                        end else begin
                            post_cnt_q <= post_len;
                            state_q    <= ST_TRIG;
                        end
                    end
                end
                ST_TRIG: begin
                    wr_ptr_q   <= wr_ptr_d;
                    fill_cnt_q <= fill_cnt_d;
                    post_cnt_q <= post_cnt_q - 4'd1;
                    if (post_cnt_q == 4'd1) begin
                        // A full buffer gives fill[3:0]=0, so rd_ptr lands on wr_ptr: the oldest entry.
                        rd_ptr_q   <= wr_ptr_d - fill_cnt_d[PTR_W-1:0];
                        rd_level_q <= fill_cnt_d;
                        trig_pos_q <= fill_cnt_d[PTR_W-1:0] - 4'd1 - post_len_q;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cap_start) begin
                        wr_ptr_q   <= '0;
                        fill_cnt_q <= '0;
                        rd_level_q <= '0;
                        trig_pos_q <= '0;
                        state_q    <= ST_ARMED;
                    end else if (rd_fire) begin
                        rd_ptr_q   <= rd_ptr_q + 4'd1;
                        rd_level_q <= rd_level_q - 5'd1;
                        rd_valid_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mcu_cap_ram u_ram (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (test_in),
        .re_i    (rd_fire),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_level  = rd_level_q;
    assign trig_pos  = trig_pos_q;
    assign cap_state = state_q;
    assign cap_done  = (state_q == ST_DONE);

endmodule

// File: doc/mcu_test_capture.md
MCU_TEST_CAPTURE -- requirements
Module: mcu_test_capture

Interface
REQ-001 SHALL have the following ports (clock and reset first):
- sys_clk  in  1  single clock; all logic rising-edge.
- sys_rst  in  1  synchronous reset, active-high.
- test_in  in  32  observed test bus, the MCU test-select mux output.
- cap_start  in  1  one-cycle pulse; arms a capture.
- cap_abort  in  1  one-cycle pulse; returns to IDLE.
- trig_mask  in  32  bit-enable mask for trigger compare.
- trig_value  in  32  trigger compare value.
- post_len  in  4  samples stored after the trigger sample (0..15).
- rd_req  in  1  one-cycle pulse; pops the oldest stored sample.
- rd_data  out  32  popped sample.
- rd_valid  out  1  one-cycle qualifier for rd_data.
- rd_level  out  5  samples remaining to read (0..16).
- trig_pos  out  4  read-order index of the trigger sample.
- cap_state  out  2  current FSM state.
- cap_done  out  1  high while in DONE.

Function
REQ-002 SHALL implement FSM states IDLE=0, ARMED=1, TRIG=2, DONE=3, with cap_state showing the registered state.
REQ-003 SHALL, on cap_start in IDLE or DONE, clear wr_ptr, fill_cnt, rd_level and trig_pos, then enter ARMED on the next cycle. cap_start SHALL be ignored in ARMED or TRIG.
REQ-004 SHALL, in ARMED, write test_in each cycle to a 16x32 circular buffer at wr_ptr. wr_ptr increments modulo 16; fill_cnt saturates at 16 (oldest sample overwritten).
REQ-005 SHALL detect a trigger when (test_in & trig_mask) == (trig_value & trig_mask). trig_mask=0 SHALL trigger on the first ARMED cycle.
REQ-006 SHALL write the trigger sample, load post_cnt=post_len, and enter TRIG. If post_len=0, it SHALL enter DONE directly instead.
REQ-007 SHALL, in TRIG, write one sample per cycle and decrement post_cnt. After the write with post_cnt=1 it SHALL enter DONE, so exactly post_len samples follow the trigger.
REQ-008 SHALL, on entry to DONE, set rd_ptr=(wr_ptr-fill_cnt) mod 16, rd_level=fill_cnt, and trig_pos=fill_cnt-1-post_len (4-bit).
REQ-009 SHALL, in DONE with rd_level>0, answer each rd_req with rd_data=the sample at rd_ptr and rd_valid=1 exactly one cycle later. rd_ptr SHALL increment modulo 16 and rd_level SHALL decrement.
REQ-010 SHALL ignore rd_req when rd_level=0 or when not in DONE (no rd_valid, no pointer change). Back-to-back rd_req every cycle SHALL be supported.
REQ-011 SHALL write no buffer entry in IDLE or DONE.
REQ-012 SHALL, on cap_abort in any state, enter IDLE next cycle and zero rd_level and trig_pos. Buffer contents are don't-care. cap_abort SHALL take priority over a simultaneous cap_start or rd_req.
REQ-013 SHALL drive cap_done=(state==DONE). rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-014 SHALL, on sys_rst=1 at a clock edge, set: state=IDLE; wr_ptr, rd_ptr, fill_cnt, post_cnt = 0; rd_data=0, rd_valid=0, rd_level=0, trig_pos=0, cap_done=0.
REQ-015 SHALL give sys_rst priority over all other inputs, including mid-capture and mid-readout. Buffer RAM content is not reset.

Structure
REQ-016 SHALL place state encodings, DEPTH=16, and PTR_W=4 in a shared package mcu_cap_pkg.
REQ-017 SHALL instantiate one sub-module, mcu_cap_ram: 16x32, synchronous write, registered read, one read port and one write port.
REQ-018 SHALL keep the control logic (FSM, pointers, counters) in mcu_test_capture.

Verification
REQ-019 Free-run trigger: mask=0, post_len=3, cap_start -> DONE after 4 samples; rd_level=4, trig_pos=0; reads return test_in from cycles t0..t3 in order.
REQ-020 Wrap: mask=FFFFFFFF, value=0x40, test_in=counter from 0, post_len=5 -> rd_level=16, trig_pos=10; reads return 0x36..0x45.
REQ-021 post_len=0, trigger on the 3rd ARMED sample -> rd_level=3, trig_pos=2, DONE one cycle after the trigger.
REQ-022 Readout edge cases: back-to-back rd_req x17 with rd_level=16 -> 16 rd_valid pulses, the 17th ignored, rd_level=0.
REQ-023 Aborts and collisions: cap_abort together with cap_start in TRIG -> IDLE, rd_level=0. cap_start in ARMED -> no effect.
REQ-024 sys_rst mid-readout at rd_level=7 -> all outputs 0, state IDLE next cycle; a new cap_start operates normally.
